// File: rtl/vdp_cartridge_cpu_port.sv
// vdp_cartridge_cpu_port: MSX slot I/O front end for VDP ports, register writes and VRAM request handshake
module vdp_cartridge_cpu_port #(
  parameter logic [7:0] IO_BASE = 8'h88
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_iorq_n,
  input  logic        slot_rd_n,
  input  logic        slot_wr_n,
  input  logic [7:0]  slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_data_dir,
  output logic        slot_wait,
  input  logic        init_busy,
  input  logic [7:0]  status_data,
  output logic        status_read,
  output logic        reg_wr,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        vram_req,
  output logic        vram_wr,
  output logic [16:0] vram_address,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ack,
  input  logic [7:0]  vram_rdata
);
  logic [1:0] iorq_sr, rd_sr, wr_sr;
  logic iorq_s, rd_s, wr_s;
  logic armed, stall, pend_valid, pend_rd, first_flag;
  logic [1:0] pend_port;
  logic [7:0] pend_data, latch, prefetch;
  logic [16:0] ptr;
  logic [2:0] r14;
  logic fire, ev_rd, ev_vram, defer, exec;
  logic [1:0] ev_port;
  logic [7:0] ev_data;
  logic [16:0] set_addr;
  assign iorq_s = iorq_sr[1];
  assign rd_s = rd_sr[1];
  assign wr_s = wr_sr[1];
  assign slot_wait = init_busy | stall;
  // A held access blocks new detection; the slot stays un-armed-consumed until it can be taken.
  always_comb begin
    fire = armed && !iorq_s && (!rd_s || !wr_s) && slot_a[7:2] == IO_BASE[7:2] && !pend_valid;
    ev_port = fire ? slot_a[1:0] : pend_port;
    ev_rd = fire ? !rd_s : pend_rd;
    ev_data = fire ? slot_d_in : pend_data;
    ev_vram = ev_port == 2'd0 || (ev_port == 2'd1 && !ev_rd && first_flag && ev_data[7:6] == 2'b00);
    defer = fire && ev_vram && vram_req;
    exec = (fire && !defer) || (pend_valid && !vram_req);
    set_addr = {r14, ev_data[5:0], latch};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iorq_sr <= 2'b11;
      rd_sr <= 2'b11;
      wr_sr <= 2'b11;
      armed <= 1'b0;
      stall <= 1'b0;
      pend_valid <= 1'b0;
      pend_rd <= 1'b0;
      pend_port <= 2'd0;
      pend_data <= 8'd0;
      first_flag <= 1'b0;
      latch <= 8'd0;
      prefetch <= 8'd0;
      ptr <= 17'd0;
      r14 <= 3'd0;
      slot_d_out <= 8'd0;
      slot_data_dir <= 1'b0;
      status_read <= 1'b0;
      reg_wr <= 1'b0;
      reg_num <= 6'd0;
      reg_data <= 8'd0;
      vram_req <= 1'b0;
      vram_wr <= 1'b0;
      vram_address <= 17'd0;
      vram_wdata <= 8'd0;
    end else begin
      iorq_sr <= {iorq_sr[0], slot_iorq_n};
      rd_sr <= {rd_sr[0], slot_rd_n};
      wr_sr <= {wr_sr[0], slot_wr_n};
      reg_wr <= 1'b0;
      status_read <= 1'b0;
      armed <= iorq_s | (armed & !fire);
      if (fire && !rd_s) slot_data_dir <= 1'b1;
      else if (rd_s || iorq_s) slot_data_dir <= 1'b0;
      if (vram_req && vram_ack) begin
        vram_req <= 1'b0;
        if (!vram_wr) begin
          prefetch <= vram_rdata;
          ptr <= ptr + 17'd1;
        end
      end
      // An access landing on the ack clock is queued without raising WAIT.
      if (defer) begin
        pend_valid <= 1'b1;
        pend_port <= ev_port;
        pend_rd <= ev_rd;
        pend_data <= ev_data;
        stall <= !vram_ack;
      end
      if (exec) begin
        pend_valid <= 1'b0;
        stall <= 1'b0;
        if (ev_port == 2'd0) begin
          first_flag <= 1'b0;
          vram_req <= 1'b1;
          vram_wr <= !ev_rd;
          vram_address <= ptr;
          vram_wdata <= ev_data;
          if (ev_rd) slot_d_out <= prefetch;
          else ptr <= ptr + 17'd1;
        end else if (ev_port == 2'd1) begin
          if (ev_rd) begin
            slot_d_out <= status_data;
            status_read <= 1'b1;
            first_flag <= 1'b0;
          end else if (!first_flag) begin
            latch <= ev_data;
            first_flag <= 1'b1;
          end else begin
            first_flag <= 1'b0;
            if (ev_data[7]) begin
              reg_wr <= 1'b1;
              reg_num <= ev_data[5:0];
              reg_data <= latch;
              if (ev_data[5:0] == 6'd14) begin
                r14 <= latch[2:0];
                ptr[16:14] <= latch[2:0];
              end
            end else begin
              ptr <= set_addr;
              if (!ev_data[6]) begin
                vram_req <= 1'b1;
                vram_wr <= 1'b0;
                vram_address <= set_addr;
              end
            end
          end
        end else if (ev_rd) begin
          slot_d_out <= 8'hFF;
        end else begin
          reg_wr <= 1'b1;
          reg_num <= {5'b01000, ev_port[0]};
          reg_data <= ev_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_vdp_cartridge_cpu_port.sv
// tb_vdp_cartridge_cpu_port: scoreboard bench driving slot I/O cycles against a delayed-ack VRAM responder
module tb_vdp_cartridge_cpu_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slot_iorq_n = 1'b1, slot_rd_n = 1'b1, slot_wr_n = 1'b1;
  logic [7:0] slot_a = 8'h00, slot_d_in = 8'h00;
  logic [7:0] slot_d_out;
  logic slot_data_dir, slot_wait;
  logic init_busy = 1'b0;
  logic [7:0] status_data = 8'h00;
  logic status_read, reg_wr;
  logic [5:0] reg_num;
  logic [7:0] reg_data;
  logic vram_req, vram_wr;
  logic [16:0] vram_address;
  logic [7:0] vram_wdata;
  logic vram_ack = 1'b0;
  logic [7:0] vram_rdata = 8'h00;

  typedef struct {bit wr; logic [16:0] a; logic [7:0] d;} vexp_t;
  typedef struct {logic [5:0] n; logic [7:0] d;} rexp_t;
  vexp_t vq[$];
  rexp_t regq[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] rdata_q[$];
  int tests = 0, fails = 0;
  int ack_delay = 10;
  logic req_d = 1'b0;

  vdp_cartridge_cpu_port dut (
    .clk(clk), .reset(reset),
    .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_data_dir(slot_data_dir), .slot_wait(slot_wait),
    .init_busy(init_busy), .status_data(status_data), .status_read(status_read),
    .reg_wr(reg_wr), .reg_num(reg_num), .reg_data(reg_data),
    .vram_req(vram_req), .vram_wr(vram_wr), .vram_address(vram_address),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_vram(input bit wr, input logic [16:0] a, input logic [7:0] d);
    vexp_t e;
    e.wr = wr; e.a = a; e.d = d;
    vq.push_back(e);
  endtask

  task automatic exp_reg(input logic [5:0] n, input logic [7:0] d);
    rexp_t e;
    e.n = n; e.d = d;
    regq.push_back(e);
  endtask

  task automatic io(input logic [1:0] port, input bit rd, input logic [7:0] d, input bit exp_wait);
    int cnt;
    @(negedge clk);
    slot_a = 8'h88 | {6'd0, port};
    slot_d_in = d;
    slot_iorq_n = 1'b0;
    if (rd) slot_rd_n = 1'b0; else slot_wr_n = 1'b0;
    repeat (20) @(negedge clk);
    chk("slot_wait_during_access", {31'd0, slot_wait}, {31'd0, exp_wait});
    cnt = 0;
    while (slot_wait && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (slot_wait) chk("wait_timeout", 32'd1, 32'd0);
    slot_iorq_n = 1'b1;
    slot_rd_n = 1'b1;
    slot_wr_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // VRAM responder: acknowledges each request after ack_delay clocks
  initial forever begin
    @(negedge clk);
    if (vram_req && !reset) begin
      repeat (ack_delay - 1) @(negedge clk);
      vram_rdata = 8'h00;
      if (!vram_wr && rdata_q.size() > 0) vram_rdata = rdata_q.pop_front();
      vram_ack = 1'b1;
      @(negedge clk);
      vram_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    vexp_t e;
    if (!reset && vram_req && !req_d) begin
      if (vq.size() == 0) chk("vram_unexpected", 32'd1, 32'd0);
      else begin
        e = vq.pop_front();
        chk("vram_wr", {31'd0, vram_wr}, {31'd0, e.wr});
        chk("vram_address", {15'd0, vram_address}, {15'd0, e.a});
        if (e.wr) chk("vram_wdata", {24'd0, vram_wdata}, {24'd0, e.d});
      end
    end
    req_d = vram_req;
  end

  always @(negedge clk) begin
    rexp_t e;
    if (!reset && reg_wr) begin
      if (regq.size() == 0) chk("reg_unexpected", 32'd1, 32'd0);
      else begin
        e = regq.pop_front();
        chk("reg_num", {26'd0, reg_num}, {26'd0, e.n});
        chk("reg_data", {24'd0, reg_data}, {24'd0, e.d});
      end
    end
  end

  always @(posedge slot_rd_n) begin
    logic [7:0] e;
    if (rd_exp_q.size() == 0) chk("read_unexpected", 32'd1, 32'd0);
    else begin
      e = rd_exp_q.pop_front();
      chk("read_data", {24'd0, slot_d_out}, {24'd0, e});
      chk("read_dir", {31'd0, slot_data_dir}, 32'd1);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vram_req", {31'd0, vram_req}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_status_read", {31'd0, status_read}, 32'd0);
    chk("rst_data_dir", {31'd0, slot_data_dir}, 32'd0);
    chk("rst_d_out", {24'd0, slot_d_out}, 32'd0);
    chk("rst_address", {15'd0, vram_address}, 32'd0);
    chk("rst_wait", {31'd0, slot_wait}, 32'd0);
    init_busy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("init_wait_high", {31'd0, slot_wait}, 32'd1);
    init_busy = 1'b0;
    @(negedge clk);
    chk("init_wait_low", {31'd0, slot_wait}, 32'd0);
    // sequential write fill from address 0
    io(2'd1, 1'b0, 8'h00, 1'b0);
    io(2'd1, 1'b0, 8'h40, 1'b0);
    for (int i = 0; i < 256; i++) begin
      exp_vram(1'b1, 17'(i), 8'(i));
      io(2'd0, 1'b0, 8'(i), 1'b0);
    end
    // register writes leave the pointer alone
    exp_reg(6'd0, 8'h06);
    io(2'd1, 1'b0, 8'h06, 1'b0);
    io(2'd1, 1'b0, 8'h80, 1'b0);
    exp_reg(6'd1, 8'h40);
    io(2'd1, 1'b0, 8'h40, 1'b0);
    io(2'd1, 1'b0, 8'h81, 1'b0);
    exp_vram(1'b1, 17'h00100, 8'h33);
    io(2'd0, 1'b0, 8'h33, 1'b0);
    // pointer wrap at the top of 128K
    exp_reg(6'd14, 8'h07);
    io(2'd1, 1'b0, 8'h07, 1'b0);
    io(2'd1, 1'b0, 8'h8E, 1'b0);
    io(2'd1, 1'b0, 8'hFF, 1'b0);
    io(2'd1, 1'b0, 8'h7F, 1'b0);
    exp_vram(1'b1, 17'h1FFFF, 8'h11);
    io(2'd0, 1'b0, 8'h11, 1'b0);
    exp_vram(1'b1, 17'h00000, 8'h22);
    io(2'd0, 1'b0, 8'h22, 1'b0);
    exp_reg(6'd14, 8'h00);
    io(2'd1, 1'b0, 8'h00, 1'b0);
    io(2'd1, 1'b0, 8'h8E, 1'b0);
    // read-ahead and prefetched port 0 reads
    rdata_q.push_back(8'hA5);
    rdata_q.push_back(8'h5A);
    io(2'd1, 1'b0, 8'h10, 1'b0);
    exp_vram(1'b0, 17'h00010, 8'h00);
    io(2'd1, 1'b0, 8'h00, 1'b0);
    exp_vram(1'b0, 17'h00011, 8'h00);
    rd_exp_q.push_back(8'hA5);
    io(2'd0, 1'b1, 8'h00, 1'b0);
    exp_vram(1'b0, 17'h00012, 8'h00);
    rd_exp_q.push_back(8'h5A);
    io(2'd0, 1'b1, 8'h00, 1'b0);
    // status, port 2/3
    status_data = 8'h9C;
    rd_exp_q.push_back(8'h9C);
    io(2'd1, 1'b1, 8'h00, 1'b0);
    exp_reg(6'd16, 8'h55);
    io(2'd2, 1'b0, 8'h55, 1'b0);
    rd_exp_q.push_back(8'hFF);
    io(2'd3, 1'b1, 8'h00, 1'b0);
    exp_reg(6'd17, 8'h21);
    io(2'd3, 1'b0, 8'h21, 1'b0);
    // slow ack forces WAIT on the second write
    ack_delay = 300;
    io(2'd1, 1'b0, 8'h00, 1'b0);
    io(2'd1, 1'b0, 8'h40, 1'b0);
    exp_vram(1'b1, 17'h00000, 8'h77);
    io(2'd0, 1'b0, 8'h77, 1'b0);
    exp_vram(1'b1, 17'h00001, 8'h88);
    io(2'd0, 1'b0, 8'h88, 1'b1);
    repeat (400) @(negedge clk);
    chk("vram_queue_drained", vq.size(), 32'd0);
    chk("reg_queue_drained", regq.size(), 32'd0);
    chk("read_queue_drained", rd_exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
